// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC-driven instruction fetch with redirect/halt handling and a fetch buffer toward decode
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        halted
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] MB = 32'(MEM_BYTES);
    localparam logic [31:0] PC0 = (RESET_PC % MB) & ~32'd3;
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
    logic [AW:0] count, count_n;
    logic [63:0] fifo_mem [FIFO_DEPTH];
    logic [63:0] head_n;
    logic pop, push;
    assign imem_pc = fetch_pc;
    assign out_valid = count != '0;
    assign halted = state == HALT;
    always_comb begin
        pop = out_valid && out_ready && !redirect_valid;
        push = state == RUN && !redirect_valid && imem_inst != '0 && (count < DEPTH || pop);
        rd_n = redirect_valid ? '0 : rd_ptr + AW'(pop);
        wr_n = redirect_valid ? '0 : wr_ptr + AW'(push);
        count_n = redirect_valid ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
        // a push landing on the new head slot must bypass the buffer array
        head_n = (push && wr_ptr == rd_n) ? {fetch_pc, imem_inst} : fifo_mem[rd_n];
        fetch_pc_n = redirect_valid ? (redirect_pc & ~32'd3) % MB :
                     push ? (fetch_pc + 32'd4 >= MB ? '0 : fetch_pc + 32'd4) : fetch_pc;
        state_n = redirect_valid ? RUN : (state == RUN && imem_inst == '0) ? HALT : state;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            fetch_pc <= PC0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            out_inst <= '0;
            out_pc <= '0;
        end else begin
            state <= state_n;
            fetch_pc <= fetch_pc_n;
            rd_ptr <= rd_n;
            wr_ptr <= wr_n;
            count <= count_n;
            if (count_n != '0 && !redirect_valid) {out_pc, out_inst} <= head_n;
        end
    end
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {fetch_pc, imem_inst};
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed stimulus with a queue scoreboard checking delivered fetch entries
module tb_inst_fetch_unit;
    logic clk = 0;
    logic reset = 0;
    logic [31:0] imem_pc, imem_inst, redirect_pc, out_inst, out_pc;
    logic redirect_valid = 0, out_ready = 0, out_valid, halted;
    logic [7:0] mem [1024];
    logic [31:0] prog [11];
    logic [63:0] exp_q [$];
    logic [63:0] e;
    logic [9:0] a;
    int tests = 0, fails = 0;

    inst_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_pc(imem_pc), .imem_inst(imem_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        a = imem_pc[9:0];
        imem_inst = {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic setw(input int adr, input logic [31:0] w);
        mem[adr] = w[31:24];
        mem[adr + 1] = w[23:16];
        mem[adr + 2] = w[15:8];
        mem[adr + 3] = w[7:0];
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_prog();
        for (int i = 0; i < 11; i++) exp_q.push_back({32'(i * 4), prog[i]});
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] w);
        exp_q.push_back({pc, w});
    endtask

    task automatic do_reset(input logic rdy);
        reset = 0;
        redirect_valid = 0;
        out_ready = rdy;
        tick(2);
        reset = 1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1;
        redirect_pc = pc;
        tick(1);
        redirect_valid = 0;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected delivery: got pc 0x%08h expected none", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e[63:32]);
                check("out_inst", out_inst, e[31:0]);
            end
        end
    end

    initial begin
        prog = '{32'h00A00093, 32'h00100113, 32'h002081B3, 32'h00310233, 32'h004182B3,
                 32'h00520333, 32'h006283B3, 32'h00730433, 32'h008384B3, 32'h00940533,
                 32'h00D605B3};
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 11; i++) setw(i * 4, prog[i]);
        setw(700, 32'h00201F73);
        setw(704, 32'h00101EF3);
        setw(708, 32'h35C00E67);
        setw(780, 32'h34202F73);
        setw(784, 32'h00000013);
        setw(788, 32'h30200073);
        setw(1020, 32'h00C0006F);
        redirect_pc = 0;

        // 1: straight-line run to the zero word
        reset = 0;
        out_ready = 1;
        tick(2);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst out_pc", out_pc, 0);
        check("rst out_inst", out_inst, 0);
        check("rst halted", 32'(halted), 0);
        check("rst imem_pc", imem_pc, 0);
        push_prog();
        reset = 1;
        tick(1);
        check("t1 first latency valid", 32'(out_valid), 1);
        check("t1 first pc", out_pc, 0);
        tick(11);
        check("t1 drained", 32'(exp_q.size()), 0);
        check("t1 halted", 32'(halted), 1);
        check("t1 imem_pc", imem_pc, 44);
        check("t1 out_valid low", 32'(out_valid), 0);
        tick(2);
        check("t1 imem_pc hold", imem_pc, 44);

        // 4: redirect out of HALT
        redirect(780);
        check("t4 halted clear", 32'(halted), 0);
        check("t4 imem_pc", imem_pc, 780);
        push_exp(780, 32'h34202F73);
        push_exp(784, 32'h00000013);
        push_exp(788, 32'h30200073);
        tick(4);
        check("t4 drained", 32'(exp_q.size()), 0);
        check("t4 halted", 32'(halted), 1);
        check("t4 imem_pc", imem_pc, 792);

        // 5: unaligned target near the top wraps to 0
        redirect(32'h3FE);
        check("t5 imem_pc", imem_pc, 1020);
        push_exp(1020, 32'h00C0006F);
        push_prog();
        tick(13);
        check("t5 drained", 32'(exp_q.size()), 0);
        check("t5 halted", 32'(halted), 1);
        out_ready = 0;
        redirect(0);
        tick(4);
        check("t5 full imem_pc", imem_pc, 16);
        out_ready = 1;
        redirect(700);
        check("t5 flush valid", 32'(out_valid), 0);
        push_exp(700, 32'h00201F73);
        push_exp(704, 32'h00101EF3);
        push_exp(708, 32'h35C00E67);
        tick(4);
        check("t5 flush drained", 32'(exp_q.size()), 0);

        // 2: back-pressure fills the buffer, then drains without gap
        do_reset(0);
        tick(6);
        check("t2 imem_pc hold", imem_pc, 16);
        check("t2 out_valid", 32'(out_valid), 1);
        check("t2 stable pc", out_pc, 0);
        check("t2 stable inst", out_inst, 32'h00A00093);
        push_prog();
        out_ready = 1;
        tick(11);
        check("t2 drained", 32'(exp_q.size()), 0);

        // 3: redirect with three entries buffered
        do_reset(0);
        tick(3);
        check("t3 buffered", 32'(out_valid), 1);
        redirect(700);
        check("t3 valid after redirect", 32'(out_valid), 0);
        check("t3 imem_pc", imem_pc, 700);
        push_exp(700, 32'h00201F73);
        push_exp(704, 32'h00101EF3);
        push_exp(708, 32'h35C00E67);
        out_ready = 1;
        tick(4);
        check("t3 drained", 32'(exp_q.size()), 0);
        check("t3 halted", 32'(halted), 1);
        check("t3 imem_pc", imem_pc, 712);

        // 6: asynchronous reset mid-cycle with a full buffer
        do_reset(0);
        tick(5);
        check("t6 full valid", 32'(out_valid), 1);
        #2;
        reset = 0;
        #1;
        check("t6 async valid", 32'(out_valid), 0);
        check("t6 async imem_pc", imem_pc, 0);
        tick(1);
        out_ready = 1;
        push_prog();
        reset = 1;
        tick(12);
        check("t6 drained", 32'(exp_q.size()), 0);
        check("t6 halted", 32'(halted), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
